wb_stage: RTL and testbench

//   MEM/WB pipeline register plus writeback logic for the RV32I 5-stage pipeline.

---
 rtl/wb_stage.sv | 162 ++++++++++++++++
 tb/tb_wb_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and writeback logic for the RV32I
// five-stage pipeline. It captures the MEM-stage results, extracts and
// extends load data, picks the writeback source, drives the register-file
// write port, forwards same-cycle writes to the ID read ports and counts
// retired instructions.
module wb_stage #(
   parameter int XLEN  = 32,
   parameter int RA_W  = 5,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             mem_valid_i,
   input  logic [XLEN-1:0]  mem_alu_i,
   input  logic [XLEN-1:0]  mem_pc4_i,
   input  logic [XLEN-1:0]  mem_rdata_i,
   input  logic [2:0]       mem_funct3_i,
   input  logic [1:0]       mem_wbsel_i,
   input  logic [RA_W-1:0]  mem_rd_i,
   input  logic             mem_regwen_i,
   output logic             RegWEn,
   output logic [RA_W-1:0]  AddrD,
   output logic [XLEN-1:0]  DataD,
   input  logic [RA_W-1:0]  rs1_addr_i,
   input  logic [RA_W-1:0]  rs2_addr_i,
   input  logic [XLEN-1:0]  rf_a_i,
   input  logic [XLEN-1:0]  rf_b_i,
   output logic [XLEN-1:0]  rs1_data_o,
   output logic [XLEN-1:0]  rs2_data_o,
   output logic [CNT_W-1:0] instret_o
);

   // Writeback source selector encodings.
   localparam logic [1:0] WbSelAlu    = 2'd0;
   localparam logic [1:0] WbSelLoad   = 2'd1;
   localparam logic [1:0] WbSelPc4    = 2'd2;
   localparam logic [1:0] WbSelAluAlt = 2'd3;

   // Load funct3 encodings; anything not listed is treated as a full word.
   localparam logic [2:0] F3Lb  = 3'b000;
   localparam logic [2:0] F3Lh  = 3'b001;
   localparam logic [2:0] F3Lbu = 3'b100;
   localparam logic [2:0] F3Lhu = 3'b101;

   // WB pipeline register contents.
   logic             wbValid_q,  wbValid_d;
   logic [XLEN-1:0]  wbAlu_q;
   logic [XLEN-1:0]  wbPc4_q;
   logic [XLEN-1:0]  wbRdata_q;
   logic [2:0]       wbFunct3_q;
   logic [1:0]       wbWbsel_q;
   logic [RA_W-1:0]  wbRd_q;
   logic             wbRegwen_q;
   logic [CNT_W-1:0] instret_q,  instret_d;

   // Load extraction intermediates.
   logic [1:0]       loadOff;
   logic [7:0]       loadByte;
   logic [15:0]      loadHalf;
   logic [XLEN-1:0]  loadData;
   logic [XLEN-1:0]  wbData;
   logic             wbWrite;

   // A flushed instruction is captured as a bubble so it neither writes nor
   // counts in the following cycle; the retire counter advances whenever the
   // instruction currently sitting in WB is real.
   always_comb begin
      wbValid_d = mem_valid_i & ~flush_i;
      instret_d = instret_q + {{(CNT_W-1){1'b0}}, wbValid_q};
   end

   // The WB register loads every edge with no hold; stalls show up as
   // bubbles. Reset clears everything so the write port and counter are
   // forced idle immediately, dropping any pending write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbValid_q  <= 1'b0;
         wbAlu_q    <= '0;
         wbPc4_q    <= '0;
         wbRdata_q  <= '0;
         wbFunct3_q <= '0;
         wbWbsel_q  <= '0;
         wbRd_q     <= '0;
         wbRegwen_q <= 1'b0;
         instret_q  <= '0;
      end else begin
         wbValid_q  <= wbValid_d;
         wbAlu_q    <= mem_alu_i;
         wbPc4_q    <= mem_pc4_i;
         wbRdata_q  <= mem_rdata_i;
         wbFunct3_q <= mem_funct3_i;
         wbWbsel_q  <= mem_wbsel_i;
         wbRd_q     <= mem_rd_i;
         wbRegwen_q <= mem_regwen_i;
         instret_q  <= instret_d;
      end
   end

   // Pick the addressed byte and half-word out of the aligned memory word
   // using the low address bits; half-word selection ignores bit 0.
   always_comb begin
      loadOff  = wbAlu_q[1:0];
      loadByte = wbRdata_q[7:0];
      case (loadOff)
         2'd0:    loadByte = wbRdata_q[7:0];
         2'd1:    loadByte = wbRdata_q[15:8];
         2'd2:    loadByte = wbRdata_q[23:16];
         default: loadByte = wbRdata_q[31:24];
      endcase
      loadHalf = loadOff[1] ? wbRdata_q[31:16] : wbRdata_q[15:0];
   end

   // Sign- or zero-extend the selected piece according to the load type;
   // unrecognised codes fall back to the whole word.
   always_comb begin
      loadData = wbRdata_q;
      case (wbFunct3_q)
         F3Lb:    loadData = {{(XLEN-8){loadByte[7]}}, loadByte};
         F3Lbu:   loadData = {{(XLEN-8){1'b0}}, loadByte};
         F3Lh:    loadData = {{(XLEN-16){loadHalf[15]}}, loadHalf};
         F3Lhu:   loadData = {{(XLEN-16){1'b0}}, loadHalf};
         default: loadData = wbRdata_q;
      endcase
   end

   // Writeback source mux. It follows wbsel regardless of the write enable,
   // so an idle slot after reset presents the zeroed ALU field.
   always_comb begin
      wbData = wbAlu_q;
      case (wbWbsel_q)
         WbSelAlu:    wbData = wbAlu_q;
         WbSelLoad:   wbData = loadData;
         WbSelPc4:    wbData = wbPc4_q;
         WbSelAluAlt: wbData = wbAlu_q;
         default:     wbData = wbAlu_q;
      endcase
   end

   // Register-file write port. Writes to x0 are suppressed here, which is
   // also what keeps address 0 out of the bypass below.
   always_comb begin
      wbWrite = wbValid_q & wbRegwen_q & (wbRd_q != '0);
      RegWEn  = wbWrite;
      AddrD   = wbRd_q;
      DataD   = wbData;
   end

   // Same-cycle forwarding: the register file only commits at the end of
   // this cycle, so an ID read of the register being written takes the
   // writeback value instead of the stale array contents.
   always_comb begin
      rs1_data_o = (wbWrite && (rs1_addr_i == wbRd_q)) ? wbData : rf_a_i;
      rs2_data_o = (wbWrite && (rs2_addr_i == wbRd_q)) ? wbData : rf_b_i;
   end

   // Retired-instruction count, wrapping naturally at its width.
   always_comb begin
      instret_o = instret_q;
   end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed bench for wb_stage. A behavioural model of the WB
// slot (what instruction sits there, what it should write, how many have
// retired) is checked against the DUT every falling clock edge, and directed
// sequences pin literal values worked out by hand.
module tb_wb_stage;

   localparam int XLEN  = 32;
   localparam int RA_W  = 5;
   localparam int CNT_W = 64;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             flush_i = 1'b0;
   logic             mem_valid_i = 1'b0;
   logic [XLEN-1:0]  mem_alu_i = '0;
   logic [XLEN-1:0]  mem_pc4_i = '0;
   logic [XLEN-1:0]  mem_rdata_i = '0;
   logic [2:0]       mem_funct3_i = '0;
   logic [1:0]       mem_wbsel_i = '0;
   logic [RA_W-1:0]  mem_rd_i = '0;
   logic             mem_regwen_i = 1'b0;
   logic             RegWEn;
   logic [RA_W-1:0]  AddrD;
   logic [XLEN-1:0]  DataD;
   logic [RA_W-1:0]  rs1_addr_i = '0;
   logic [RA_W-1:0]  rs2_addr_i = '0;
   logic [XLEN-1:0]  rf_a_i = '0;
   logic [XLEN-1:0]  rf_b_i = '0;
   logic [XLEN-1:0]  rs1_data_o;
   logic [XLEN-1:0]  rs2_data_o;
   logic [CNT_W-1:0] instret_o;

   int checks = 0;
   int errors = 0;

   // Model of the instruction occupying the WB slot.
   logic             mValid = 1'b0;
   logic [31:0]      mAlu = '0;
   logic [31:0]      mPc4 = '0;
   logic [31:0]      mRdata = '0;
   logic [2:0]       mF3 = '0;
   logic [1:0]       mWbsel = '0;
   logic [4:0]       mRd = '0;
   logic             mRegwen = 1'b0;
   logic [63:0]      mInstret = '0;

   wb_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (flush_i),
      .mem_valid_i  (mem_valid_i),
      .mem_alu_i    (mem_alu_i),
      .mem_pc4_i    (mem_pc4_i),
      .mem_rdata_i  (mem_rdata_i),
      .mem_funct3_i (mem_funct3_i),
      .mem_wbsel_i  (mem_wbsel_i),
      .mem_rd_i     (mem_rd_i),
      .mem_regwen_i (mem_regwen_i),
      .RegWEn       (RegWEn),
      .AddrD        (AddrD),
      .DataD        (DataD),
      .rs1_addr_i   (rs1_addr_i),
      .rs2_addr_i   (rs2_addr_i),
      .rf_a_i       (rf_a_i),
      .rf_b_i       (rf_b_i),
      .rs1_data_o   (rs1_data_o),
      .rs2_data_o   (rs2_data_o),
      .instret_o    (instret_o)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison; every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Value a load returns: shift the wanted lane down, mask it, and extend
   // by adding the all-ones upper part when the sign bit is set.
   function automatic logic [31:0] modelLoad(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
      logic [31:0] b;
      logic [31:0] h;
      b = (w >> (8 * int'(off))) & 32'h0000_00FF;
      h = (w >> (16 * int'(off[1]))) & 32'h0000_FFFF;
      case (f3)
         3'b000:  return (b >= 32'd128) ? (b + 32'hFFFF_FF00) : b;
         3'b100:  return b;
         3'b001:  return (h >= 32'd32768) ? (h + 32'hFFFF_0000) : h;
         3'b101:  return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] modelData();
      if (mWbsel == 2'd1) return modelLoad(mRdata, mF3, mAlu[1:0]);
      if (mWbsel == 2'd2) return mPc4;
      return mAlu;
   endfunction

   function automatic logic modelWen();
      return mValid && mRegwen && (mRd != 5'd0);
   endfunction

   // Model update: count the instruction leaving WB, then take the new one.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mValid   = 1'b0;
         mAlu     = '0;
         mPc4     = '0;
         mRdata   = '0;
         mF3      = '0;
         mWbsel   = '0;
         mRd      = '0;
         mRegwen  = 1'b0;
         mInstret = '0;
      end else begin
         if (mValid) mInstret = mInstret + 64'd1;
         mValid  = mem_valid_i && !flush_i;
         mAlu    = mem_alu_i;
         mPc4    = mem_pc4_i;
         mRdata  = mem_rdata_i;
         mF3     = mem_funct3_i;
         mWbsel  = mem_wbsel_i;
         mRd     = mem_rd_i;
         mRegwen = mem_regwen_i;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic [31:0] expData;
      logic        expWen;
      expData = modelData();
      expWen  = modelWen();
      checkOutput("cyc RegWEn",  64'(RegWEn), 64'(expWen));
      checkOutput("cyc AddrD",   64'(AddrD), 64'(mRd));
      checkOutput("cyc DataD",   64'(DataD), 64'(expData));
      checkOutput("cyc instret", instret_o, mInstret);
      checkOutput("cyc rs1",     64'(rs1_data_o), 64'((expWen && rs1_addr_i == mRd) ? expData : rf_a_i));
      checkOutput("cyc rs2",     64'(rs2_data_o), 64'((expWen && rs2_addr_i == mRd) ? expData : rf_b_i));
   end

   // Present one MEM-stage instruction and let it move into WB.
   task automatic applyStimulus(input logic valid, input logic flush, input logic [31:0] alu,
                                input logic [31:0] pc4, input logic [31:0] rdata, input logic [2:0] f3,
                                input logic [1:0] wbsel, input logic [4:0] rd, input logic regwen);
      mem_valid_i  = valid;
      flush_i      = flush;
      mem_alu_i    = alu;
      mem_pc4_i    = pc4;
      mem_rdata_i  = rdata;
      mem_funct3_i = f3;
      mem_wbsel_i  = wbsel;
      mem_rd_i     = rd;
      mem_regwen_i = regwen;
      @(posedge clk);
      #2;
   endtask

   task automatic applyBubble();
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 3'd0, 2'd0, 5'd0, 1'b0);
   endtask

   task automatic setRead(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] da, input logic [31:0] db);
      rs1_addr_i = a1;
      rs2_addr_i = a2;
      rf_a_i     = da;
      rf_b_i     = db;
      #1;
   endtask

   // Load vectors against rdata 0x80FF_7F01.
   logic [2:0]  ldF3  [10] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd1, 3'd3, 3'd0, 3'd0, 3'd5};
   logic [1:0]  ldOff [10] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2};
   logic [31:0] ldExp [10] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                               32'h80FF_7F01, 32'hFFFF_80FF, 32'h80FF_7F01, 32'h0000_007F,
                               32'hFFFF_FFFF, 32'h0000_80FF};

   initial begin
      #1 rst_n = 1'b0;

      // Reset held with random activity on every input.
      for (int i = 0; i < 4; i++) begin
         mem_valid_i  = 1'b1;
         flush_i      = 1'b0;
         mem_alu_i    = $urandom;
         mem_pc4_i    = $urandom;
         mem_rdata_i  = $urandom;
         mem_funct3_i = 3'($urandom_range(0, 7));
         mem_wbsel_i  = 2'($urandom_range(0, 3));
         mem_rd_i     = 5'($urandom_range(1, 31));
         mem_regwen_i = 1'b1;
         rf_a_i       = $urandom;
         @(posedge clk);
         #2;
         checkOutput("reset RegWEn",  64'(RegWEn), 64'd0);
         checkOutput("reset AddrD",   64'(AddrD), 64'd0);
         checkOutput("reset DataD",   64'(DataD), 64'd0);
         checkOutput("reset instret", instret_o, 64'd0);
      end
      mem_valid_i = 1'b0;
      mem_regwen_i = 1'b0;
      setRead(5'd0, 5'd0, 32'd0, 32'd0);
      rst_n = 1'b1;

      // ALU writeback with one cycle of latency.
      applyStimulus(1'b1, 1'b0, 32'h1234_5678, 32'h0000_0004, 32'hCAFE_0000, 3'd2, 2'd0, 5'd5, 1'b1);
      checkOutput("alu RegWEn",  64'(RegWEn), 64'd1);
      checkOutput("alu AddrD",   64'(AddrD), 64'd5);
      checkOutput("alu DataD",   64'(DataD), 64'h1234_5678);
      checkOutput("alu instret", instret_o, 64'd0);
      applyBubble();
      checkOutput("alu retired", instret_o, 64'd1);
      checkOutput("bubble RegWEn", 64'(RegWEn), 64'd0);

      // Load extraction; each load retires one more instruction.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0000_1000 | 32'(ldOff[i]), 32'h0, 32'h80FF_7F01, ldF3[i], 2'd1, 5'd10, 1'b1);
         checkOutput($sformatf("load%0d DataD", i), 64'(DataD), 64'(ldExp[i]));
         checkOutput($sformatf("load%0d model", i), 64'(modelData()), 64'(ldExp[i]));
         checkOutput($sformatf("load%0d instret", i), instret_o, 64'(1 + i));
      end

      // Write to x0 is suppressed but still retires.
      applyStimulus(1'b1, 1'b0, 32'h0000_0055, 32'h0, 32'h0, 3'd0, 2'd0, 5'd0, 1'b1);
      checkOutput("rd0 RegWEn",  64'(RegWEn), 64'd0);
      checkOutput("rd0 DataD",   64'(DataD), 64'h55);
      checkOutput("rd0 instret", instret_o, 64'd11);

      // Flushed instruction neither writes nor retires.
      applyStimulus(1'b1, 1'b1, 32'h0000_0066, 32'h0, 32'h0, 3'd0, 2'd0, 5'd6, 1'b1);
      checkOutput("flush RegWEn",  64'(RegWEn), 64'd0);
      checkOutput("flush AddrD",   64'(AddrD), 64'd6);
      checkOutput("flush DataD",   64'(DataD), 64'h66);
      checkOutput("flush instret", instret_o, 64'd12);
      applyBubble();
      checkOutput("flush not counted", instret_o, 64'd12);

      // Same-cycle bypass.
      applyStimulus(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'h0, 3'd0, 2'd0, 5'd7, 1'b1);
      setRead(5'd7, 5'd0, 32'h0000_0001, 32'h0000_0000);
      checkOutput("byp rs1 hit",  64'(rs1_data_o), 64'hDEAD_BEEF);
      checkOutput("byp rs2 x0",   64'(rs2_data_o), 64'h0);
      setRead(5'd3, 5'd7, 32'h0000_0011, 32'h0000_0022);
      checkOutput("byp rs1 miss", 64'(rs1_data_o), 64'h11);
      checkOutput("byp rs2 hit",  64'(rs2_data_o), 64'hDEAD_BEEF);
      applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'h0, 3'd0, 2'd0, 5'd7, 1'b1);
      setRead(5'd7, 5'd7, 32'h0000_0001, 32'h0000_0002);
      checkOutput("byp flushed rs1", 64'(rs1_data_o), 64'h1);
      checkOutput("byp flushed rs2", 64'(rs2_data_o), 64'h2);
      setRead(5'd0, 5'd0, 32'd0, 32'd0);

      // JAL link value and the alternate ALU select.
      applyStimulus(1'b1, 1'b0, 32'h0000_0999, 32'h0000_0104, 32'h0, 3'd0, 2'd2, 5'd1, 1'b1);
      checkOutput("jal RegWEn", 64'(RegWEn), 64'd1);
      checkOutput("jal AddrD",  64'(AddrD), 64'd1);
      checkOutput("jal DataD",  64'(DataD), 64'h104);
      applyStimulus(1'b1, 1'b0, 32'h0000_0ABC, 32'h0000_0108, 32'h0, 3'd0, 2'd3, 5'd2, 1'b1);
      checkOutput("sel3 DataD", 64'(DataD), 64'hABC);

      // Asynchronous reset in the middle of a cycle with a write pending.
      mem_valid_i  = 1'b1;
      mem_alu_i    = 32'h0000_0077;
      mem_rd_i     = 5'd3;
      mem_regwen_i = 1'b1;
      mem_wbsel_i  = 2'd0;
      flush_i      = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async RegWEn",  64'(RegWEn), 64'd0);
      checkOutput("async AddrD",   64'(AddrD), 64'd0);
      checkOutput("async DataD",   64'(DataD), 64'd0);
      checkOutput("async instret", instret_o, 64'd0);
      @(posedge clk);
      #2;
      checkOutput("async no write", 64'(RegWEn), 64'd0);
      checkOutput("async no data",  64'(DataD), 64'd0);
      mem_valid_i  = 1'b0;
      mem_regwen_i = 1'b0;
      rst_n = 1'b1;
      applyBubble();
      checkOutput("post reset RegWEn",  64'(RegWEn), 64'd0);
      checkOutput("post reset instret", instret_o, 64'd0);

      // Mixed traffic over a small register range so bypass hits are common.
      for (int i = 0; i < 60; i++) begin
         rs1_addr_i = 5'($urandom_range(0, 7));
         rs2_addr_i = 5'($urandom_range(0, 7));
         rf_a_i     = $urandom;
         rf_b_i     = $urandom;
         applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), $urandom, $urandom,
                       $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                       5'($urandom_range(0, 7)), 1'($urandom_range(0, 4) != 0));
      end
      applyBubble();
      applyBubble();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
